// File: rtl/mult_hilo_ctrl.sv
// HI/LO register controller for an external multi-cycle signed multiplier.
// It accepts MULT/MTHI/MTLO commands, sequences the multiplier, and flags a sticky timeout.
module mult_hilo_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_cmd,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        mult_begin,
    output logic [31:0] mult_op1,
    output logic [31:0] mult_op2,
    input  logic [63:0] mult_product,
    input  logic        mult_end,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic [5:0]  last_lat,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] CMD_MULT = 2'b00;
    localparam logic [1:0] CMD_MTHI = 2'b01;
    localparam logic [1:0] CMD_MTLO = 2'b10;
    // The counter reads 62 at the edge that closes the 63rd RUN cycle.
    localparam logic [5:0] TIMEOUT_CNT = 6'd62;
    localparam logic [5:0] CNT_MAX     = 6'd63;

    state_t     state;
    state_t     state_next;
    logic [5:0] cycle_cnt;
    logic       do_mult;
    logic       do_mthi;
    logic       do_mtlo;
    logic       finish_ok;
    logic       finish_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        do_mult        = 1'b0;
        do_mthi        = 1'b0;
        do_mtlo        = 1'b0;
        finish_ok      = 1'b0;
        finish_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    case (in_cmd)
                        CMD_MULT: begin
                            do_mult    = 1'b1;
                            state_next = RUN;
                        end
                        CMD_MTHI: do_mthi = 1'b1;
                        CMD_MTLO: do_mtlo = 1'b1;
                        default:  ;
                    endcase
                end
            end
            RUN: begin
                if (mult_end) begin
                    finish_ok  = 1'b1;
                    state_next = DONE;
                end else if (cycle_cnt == TIMEOUT_CNT) begin
                    finish_timeout = 1'b1;
                    state_next     = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready   = (state == IDLE);
    assign done       = (state == DONE);
    assign mult_begin = (state == RUN);

    // Operands stay latched after a MULT until the next MULT is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mult_op1  <= '0;
            mult_op2  <= '0;
            hi        <= '0;
            lo        <= '0;
            last_lat  <= '0;
            err       <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            if (do_mult) begin
                mult_op1  <= in_a;
                mult_op2  <= in_b;
                cycle_cnt <= '0;
            end else if (state == RUN && cycle_cnt != CNT_MAX) begin
                cycle_cnt <= cycle_cnt + 6'd1;
            end
            if (do_mthi) begin
                hi <= in_a;
            end
            if (do_mtlo) begin
                lo <= in_a;
            end
            if (finish_ok) begin
                hi       <= mult_product[63:32];
                lo       <= mult_product[31:0];
                last_lat <= cycle_cnt + 6'd1;
            end
            if (finish_timeout) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Scoreboard bench for mult_hilo_ctrl: a driver pushes expected MULT results,
// a monitor pops them on each done pulse; a stub multiplier answers with data-dependent latency.
module tb_mult_hilo_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_cmd;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        mult_begin;
    logic [31:0] mult_op1;
    logic [31:0] mult_op2;
    logic [63:0] mult_product;
    logic        mult_end;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
    logic [5:0]  last_lat;
    logic        err;

    mult_hilo_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cmd       (in_cmd),
        .in_a         (in_a),
        .in_b         (in_b),
        .mult_begin   (mult_begin),
        .mult_op1     (mult_op1),
        .mult_op2     (mult_op2),
        .mult_product (mult_product),
        .mult_end     (mult_end),
        .hi           (hi),
        .lo           (lo),
        .done         (done),
        .last_lat     (last_lat),
        .err          (err)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [5:0]  lat;
        logic        err;
        longint      t;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;
    logic [5:0]  modelLat = '0;
    logic        modelErr = 1'b0;
    bit          stubHang = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier latency: edges from acceptance to the HI/LO write is msb(|b|)+3.
    function automatic int latencyOf(input logic [31:0] b);
        longint mag;
        int     k;
        mag = longint'($signed(b));
        if (mag < 0) mag = -mag;
        k = -1;
        for (int i = 0; i < 33; i++) if (mag[i]) k = i;
        return k + 3;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge, in_valid still high.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                 input bit push);
        bit     rdy;
        bit     accepted;
        longint tAcc;
        longint p;
        exp_t   e;
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_a     = a;
        in_b     = b;
        accepted = 1'b0;
        for (int w = 0; w < 200; w++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tAcc = longint'($time);
        checkOutput("accept", 64'(accepted), 64'd1);
        if (accepted) begin
            case (cmd)
                2'b00: begin
                    if (stubHang) begin
                        modelErr = 1'b1;
                        e = '{modelHi, modelLo, modelLat, 1'b1, tAcc + 63*10 + 5};
                    end else begin
                        p = longint'($signed(a)) * longint'($signed(b));
                        modelHi  = p[63:32];
                        modelLo  = p[31:0];
                        modelLat = 6'(latencyOf(b));
                        e = '{modelHi, modelLo, modelLat, modelErr, tAcc + latencyOf(b)*10 + 5};
                    end
                    if (push) sb.push_back(e);
                end
                2'b01:   modelHi = a;
                2'b10:   modelLo = a;
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic waitDrain();
        for (int w = 0; w < 2000 && sb.size() != 0; w++) @(negedge clk);
        checkOutput("drain", 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic checkResetState();
        checkOutput("rstReady", 64'(in_ready), 64'd1);
        checkOutput("rstBegin", 64'(mult_begin), 64'd0);
        checkOutput("rstOp1", 64'(mult_op1), 64'd0);
        checkOutput("rstOp2", 64'(mult_op2), 64'd0);
        checkOutput("rstHi", 64'(hi), 64'd0);
        checkOutput("rstLo", 64'(lo), 64'd0);
        checkOutput("rstDone", 64'(done), 64'd0);
        checkOutput("rstLat", 64'(last_lat), 64'd0);
        checkOutput("rstErr", 64'(err), 64'd0);
    endtask

    // Stub multiplier: answers each new start after its operand-dependent latency.
    initial begin
        bit stubPrev;
        int lat;
        stubPrev     = 1'b0;
        mult_end     = 1'b0;
        mult_product = '0;
        forever begin
            @(negedge clk);
            if (mult_begin && !stubPrev && !stubHang) begin
                lat = latencyOf(mult_op2);
                repeat (lat - 1) @(negedge clk);
                mult_product = 64'(longint'($signed(mult_op1)) * longint'($signed(mult_op2)));
                mult_end     = 1'b1;
                @(negedge clk);
                mult_end     = 1'b0;
                mult_product = '0;
            end
            stubPrev = mult_begin;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpectedDone", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("hi", 64'(hi), 64'(e.hi));
                checkOutput("lo", 64'(lo), 64'(e.lo));
                checkOutput("lastLat", 64'(last_lat), 64'(e.lat));
                checkOutput("err", 64'(err), 64'(e.err));
                checkOutput("doneTime", 64'($time), 64'(e.t));
            end
        end
    end

    // Between two multiplier starts mult_begin must stay low for at least two cycles.
    int lowRun = 0;
    bit sawHigh = 1'b0;
    always @(negedge clk) begin
        if (mult_begin) begin
            if (sawHigh && lowRun > 0) checkOutput("beginGap", 64'(lowRun >= 2), 64'd1);
            sawHigh = 1'b1;
            lowRun  = 0;
        end else begin
            lowRun++;
        end
    end

    initial begin
        logic [1:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_cmd   = 2'b01;
        in_a     = 32'hAAAA_AAAA;
        in_b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        checkResetState();

        applyStimulus(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b1);
        applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1);
        applyStimulus(2'b00, 32'd123, 32'd0, 1'b1);
        applyStimulus(2'b00, 32'd2, 32'd3, 1'b1);
        in_valid = 1'b0;
        waitDrain();

        applyStimulus(2'b01, 32'hDEAD_BEEF, 32'd0, 1'b0);
        checkOutput("mthiHi", 64'(hi), 64'hDEAD_BEEF);
        checkOutput("mthiReady", 64'(in_ready), 64'd1);
        applyStimulus(2'b10, 32'h1234_5678, 32'd0, 1'b0);
        checkOutput("mtloLo", 64'(lo), 64'h1234_5678);
        checkOutput("mtloHi", 64'(hi), 64'hDEAD_BEEF);
        checkOutput("mtloReady", 64'(in_ready), 64'd1);
        checkOutput("mtNoDone", 64'(done), 64'd0);
        in_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            cmd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) cmd = 2'b00;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) b = -b;
            applyStimulus(cmd, a, b, 1'b1);
        end
        applyStimulus(2'b11, 32'hFFFF_0000, 32'h1, 1'b1);
        in_valid = 1'b0;
        waitDrain();
        checkOutput("randHi", 64'(hi), 64'(modelHi));
        checkOutput("randLo", 64'(lo), 64'(modelLo));

        applyStimulus(2'b01, 32'h0BAD_F00D, 32'd0, 1'b0);
        applyStimulus(2'b10, 32'hCAFE_F00D, 32'd0, 1'b0);
        stubHang = 1'b1;
        applyStimulus(2'b00, 32'd9, 32'd9, 1'b1);
        in_valid = 1'b0;
        waitDrain();
        stubHang = 1'b0;
        checkOutput("toHi", 64'(hi), 64'h0BAD_F00D);
        checkOutput("toErr", 64'(err), 64'd1);

        applyStimulus(2'b00, 32'h1234, 32'h8000_0000, 1'b0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_cmd   = 2'b01;
        in_a     = 32'h55;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        modelHi  = '0;
        modelLo  = '0;
        modelLat = '0;
        modelErr = 1'b0;
        checkResetState();
        repeat (40) @(negedge clk);
        checkOutput("postRstHi", 64'(hi), 64'd0);
        checkOutput("postRstLo", 64'(lo), 64'd0);
        checkOutput("postRstReady", 64'(in_ready), 64'd1);
        applyStimulus(2'b00, 32'd5, 32'd5, 1'b1);
        in_valid = 1'b0;
        waitDrain();
        checkOutput("fiveLo", 64'(lo), 64'd25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
